// File: rtl/ucsbece154b_branch_resolve_pkg.sv
// Shared control-flow definitions for the predictor and the resolve stage.
// It holds the opcode constants, the BTB entry field offsets and the
// control-flow classification helper.
package ucsbece154b_branch_resolve_pkg;

    // RV32I opcodes that change control flow
    localparam logic [6:0] instr_branch_op = 7'b1100011;
    localparam logic [6:0] instr_jal_op    = 7'b1101111;
    localparam logic [6:0] instr_jalr_op   = 7'b1100111;

    // BTB entry packing {B, J, tag[31:0], target[31:0]}; the predictor uses the same layout
    localparam int BTB_ENTRY_W = 66;
    localparam int BTB_B_BIT   = 65;
    localparam int BTB_J_BIT   = 64;
    localparam int BTB_TAG_MSB = 63;
    localparam int BTB_TAG_LSB = 32;
    localparam int BTB_TGT_MSB = 31;
    localparam int BTB_TGT_LSB = 0;

    typedef enum logic [1:0] {
        CF_NONE   = 2'd0,
        CF_BRANCH = 2'd1,
        CF_JUMP   = 2'd2
    } cf_kind_e;

    // Map an opcode to its kind of control flow: conditional branch, unconditional jump, or none
    function automatic cf_kind_e classify(input logic [6:0] op);
        if (op == instr_branch_op)
            return CF_BRANCH;
        else if (op == instr_jal_op || op == instr_jalr_op)
            return CF_JUMP;
        else
            return CF_NONE;
    endfunction

endpackage

// File: rtl/ucsbece154b_pred_pipereg.sv
// Pipeline register for prediction metadata. It has a valid bit and supports
// stall and flush. Priority order: reset, then flush, then stall, then load.
module ucsbece154b_pred_pipereg #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    // Valid bit: reset or flush inserts a bubble, stall holds, otherwise load
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (reset_i || flush_i)
            valid_o <= 1'b0;
        else if (!stall_i)
            valid_o <= valid_i;
    end

    // Payload: follows the load path only
    always_ff @(posedge clk) begin
        // NOTE: the payload is not reset on purpose. valid_o qualifies it, so a stale value is never acted on.
        if (!stall_i)
            data_o <= data_i;
    end

endmodule

// File: rtl/ucsbece154b_branch_resolve.sv
// Execute-stage branch resolution. It carries the fetch-time prediction through
// Decode to Execute and compares it with the real outcome. From that it drives
// the BTB and PHT updates, the GHR clear, the redirect, and the statistics counters.
module ucsbece154b_branch_resolve
    import ucsbece154b_branch_resolve_pkg::*;
#(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 5,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                               clk,
    input  logic                               reset_i,
    input  logic [31:0]                        pcF_i,
    input  logic                               BranchTakenF_i,
    input  logic [31:0]                        BTBtargetF_i,
    input  logic [NUM_GHR_BITS-1:0]            PHTreadaddressF_i,
    input  logic                               StallD_i,
    input  logic                               FlushD_i,
    input  logic                               FlushE_i,
    input  logic [6:0]                         opE_i,
    input  logic                               BranchCondE_i,
    input  logic [31:0]                        PCTargetE_i,
    output logic                               BTB_we_o,
    output logic [$clog2(NUM_BTB_ENTRIES)-1:0] BTBwriteaddress_o,
    output logic [BTB_ENTRY_W-1:0]             BTBwritedata_o,
    output logic                               PHTwe_o,
    output logic [NUM_GHR_BITS-1:0]            PHTwriteaddress_o,
    output logic                               PHTincrement_o,
    output logic                               GHRreset_o,
    output logic                               MispredictE_o,
    output logic [31:0]                        PCRedirectE_o,
    output logic [CNT_WIDTH-1:0]               BranchCount_o,
    output logic [CNT_WIDTH-1:0]               MispredictCount_o
);

    localparam int IW = $clog2(NUM_BTB_ENTRIES);

    typedef struct packed {
        logic [31:0]             pc;
        logic                    pred_taken;
        logic [31:0]             pred_target;
        logic [NUM_GHR_BITS-1:0] pht_addr;
    } meta_t;

    meta_t    meta_f, meta_d, meta_e;
    logic     valid_d, valid_e;
    cf_kind_e kind_e;
    logic     is_b, is_j, act, actual_taken, mispredict;
    logic [31:0] tag_e, pc_plus4_e;

    assign meta_f = '{pc: pcF_i, pred_taken: BranchTakenF_i,
                      pred_target: BTBtargetF_i, pht_addr: PHTreadaddressF_i};

    ucsbece154b_pred_pipereg #(.WIDTH($bits(meta_t))) u_pipe_d (
        .clk     (clk),
        .reset_i (reset_i),
        .stall_i (StallD_i),
        .flush_i (FlushD_i),
        .valid_i (1'b1),
        .data_i  (meta_f),
        .valid_o (valid_d),
        .data_o  (meta_d)
    );

    ucsbece154b_pred_pipereg #(.WIDTH($bits(meta_t))) u_pipe_e (
        .clk     (clk),
        .reset_i (reset_i),
        .stall_i (1'b0),
        .flush_i (FlushE_i),
        .valid_i (valid_d),
        .data_i  (meta_d),
        .valid_o (valid_e),
        .data_o  (meta_e)
    );

    assign kind_e       = classify(opE_i);
    assign is_b         = (kind_e == CF_BRANCH);
    assign is_j         = (kind_e == CF_JUMP);
    assign act          = valid_e & (is_b | is_j);
    assign actual_taken = is_j | (is_b & BranchCondE_i);
    assign pc_plus4_e   = meta_e.pc + 32'd4;
    assign tag_e        = 32'(meta_e.pc >> (IW + 2));

    // The predictor is being reset in the same cycle, so no update is sent to it then
    assign mispredict = ~reset_i & act &
                        ((meta_e.pred_taken != actual_taken) |
                         (actual_taken & (meta_e.pred_target != PCTargetE_i)));

    assign MispredictE_o     = mispredict;
    assign GHRreset_o        = mispredict;
    assign PCRedirectE_o     = actual_taken ? PCTargetE_i : pc_plus4_e;

    assign BTB_we_o          = mispredict & actual_taken;
    assign BTBwriteaddress_o = meta_e.pc[IW+1:2];

    assign PHTwe_o           = ~reset_i & valid_e & is_b;
    assign PHTwriteaddress_o = meta_e.pht_addr;
    assign PHTincrement_o    = actual_taken;

    // Assemble the BTB entry using the shared field offsets
    always_comb begin
        // NOTE: assign a default first so every bit is written on every path; otherwise a latch is inferred.
        BTBwritedata_o = '0;
        BTBwritedata_o[BTB_B_BIT]                 = is_b;
        BTBwritedata_o[BTB_J_BIT]                 = is_j;
        BTBwritedata_o[BTB_TAG_MSB:BTB_TAG_LSB]   = tag_e;
        BTBwritedata_o[BTB_TGT_MSB:BTB_TGT_LSB]   = PCTargetE_i;
    end

    // Saturating count of resolved control-flow instructions
    always_ff @(posedge clk) begin
        if (reset_i)
            BranchCount_o <= '0;
        else if (act && (BranchCount_o != '1))
            BranchCount_o <= BranchCount_o + CNT_WIDTH'(1);
    end

    // Saturating count of mispredictions
    always_ff @(posedge clk) begin
        if (reset_i)
            MispredictCount_o <= '0;
        else if (mispredict && (MispredictCount_o != '1))
            MispredictCount_o <= MispredictCount_o + CNT_WIDTH'(1);
    end

endmodule
